rc_pulse_capture: RTL and testbench

- Multi-channel RC pulse-width capture peripheral; the input-side counterpart of the servo pulse generator.
- Measures high-time of RC receiver or servo-style pulses on GPIO pins in prescaled ticks and latches each width for bus readback.
- Sits on the secondary bus beside the servo and GPIO blocks, with its own address-decode enable.
- Read data is muxed into the secondary read path by the top level.

---
 rtl/rc_pulse_capture.sv | 123 ++++++++++++
 tb/tb_rc_pulse_capture.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rc_pulse_capture.sv
// rc_pulse_capture: multi-channel RC pulse-width capture; define RCCAP_IRQ_EN to add IRQMASK (0x1C) and the Irq output.
module rc_pulse_capture #(
  parameter int NUM_CH = 8,
  parameter int PRESCALE = 16,
  parameter int TIMEOUT_TICKS = 25000
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic [4:0]        Addr,
  output logic [15:0]       DataRd,
  input  logic [15:0]       DataWr,
  input  logic              En,
  input  logic              Rd,
  input  logic              Wr,
`ifdef RCCAP_IRQ_EN
  output logic              Irq,
`endif
  input  logic [NUM_CH-1:0] P
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  typedef enum logic {IDLE, HIGH} stateT;
  logic [PW-1:0] preCnt;
  logic tick;
  logic [NUM_CH-1:0] sync1, sync2, sync3, rise, fall, enable, newFlag, lost;
  logic [15:0] width [NUM_CH];
  logic unusedBits;
  assign unusedBits = ^DataWr;
  assign tick = preCnt == PW'(PRESCALE - 1);
  assign rise = sync2 & ~sync3;
  assign fall = ~sync2 & sync3;
  // Synchronizers reset high so a pin already high at release never looks like a rise.
  always_ff @(posedge Clk or negedge ResetN)
    if (!ResetN) begin
      preCnt <= '0;
      sync1 <= '1;
      sync2 <= '1;
      sync3 <= '1;
      enable <= '1;
    end else begin
      preCnt <= tick ? '0 : preCnt + PW'(1);
      sync1 <= P;
      sync2 <= sync1;
      sync3 <= sync2;
      if (En && Wr && Addr == 5'h1D) enable <= DataWr[NUM_CH-1:0];
    end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    stateT state, stateNx;
    logic [15:0] cnt, cntNx, wreg, wregNx;
    logic [TW-1:0] to, toNx;
    logic nf, nfNx, lf, lfNx, rdClr;
    assign rdClr = En && Rd && Addr == 5'(c);
    always_comb begin
      stateNx = state;
      cntNx = cnt;
      toNx = to;
      wregNx = wreg;
      nfNx = nf & ~rdClr;
      lfNx = lf;
      if (tick && to != TW'(TIMEOUT_TICKS)) toNx = to + TW'(1);
      if (tick && to == TW'(TIMEOUT_TICKS - 1)) lfNx = 1'b1;
      if (tick && state == HIGH && cnt != 16'hFFFF) cntNx = cnt + 16'd1;
      if (state == IDLE && rise[c]) begin
        stateNx = HIGH;
        cntNx = '0;
        toNx = '0;
      end
      if (state == HIGH && fall[c]) begin
        stateNx = IDLE;
        wregNx = cnt;
        nfNx = 1'b1;
        lfNx = 1'b0;
      end
      if (!enable[c]) begin
        stateNx = IDLE;
        cntNx = '0;
        toNx = '0;
        nfNx = 1'b0;
        lfNx = 1'b0;
      end
    end
    always_ff @(posedge Clk or negedge ResetN)
      if (!ResetN) begin
        state <= IDLE;
        cnt <= '0;
        to <= '0;
        wreg <= '0;
        nf <= 1'b0;
        lf <= 1'b0;
      end else begin
        state <= stateNx;
        cnt <= cntNx;
        to <= toNx;
        wreg <= wregNx;
        nf <= nfNx;
        lf <= lfNx;
      end
    assign width[c] = wreg;
    assign newFlag[c] = nf;
    assign lost[c] = lf;
  end
`ifdef RCCAP_IRQ_EN
  logic [NUM_CH-1:0] irqMask;
  always_ff @(posedge Clk or negedge ResetN)
    if (!ResetN) begin
      irqMask <= '0;
      Irq <= 1'b0;
    end else begin
      if (En && Wr && Addr == 5'h1C) irqMask <= DataWr[NUM_CH-1:0];
      Irq <= |((newFlag | lost) & irqMask);
    end
`endif
  always_comb begin
    DataRd = '0;
    for (int i = 0; i < NUM_CH; i++) if (Addr == 5'(i)) DataRd = width[i];
    if (Addr == 5'h1D) DataRd = 16'(enable);
    if (Addr == 5'h1E) DataRd = 16'(newFlag);
    if (Addr == 5'h1F) DataRd = 16'(lost);
`ifdef RCCAP_IRQ_EN
    if (Addr == 5'h1C) DataRd = 16'(irqMask);
`endif
  end
endmodule

// File: tb/tb_rc_pulse_capture.sv
// tb_rc_pulse_capture: directed checks of rc_pulse_capture; a second PRESCALE=1 instance covers width saturation.
module tb_rc_pulse_capture;
  logic clk = 1'b0, resetN = 1'b0, en = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [4:0] addr = '0;
  logic [15:0] dataWr = '0, dataRd, d;
  logic [7:0] p = '0;
  logic resetN2 = 1'b0;
  logic [4:0] addr2 = 5'd3;
  logic [15:0] dataRd2;
  logic [3:0] p2 = '0;
  logic satDone = 1'b0;
  int errors = 0, checks = 0;
`ifdef RCCAP_IRQ_EN
  logic irq, irq2;
`endif
  always #5 clk = ~clk;
  rc_pulse_capture #(.NUM_CH(8), .PRESCALE(4), .TIMEOUT_TICKS(100)) dut (
    .Clk(clk), .ResetN(resetN), .Addr(addr), .DataRd(dataRd), .DataWr(dataWr),
    .En(en), .Rd(rd), .Wr(wr),
`ifdef RCCAP_IRQ_EN
    .Irq(irq),
`endif
    .P(p));
  rc_pulse_capture #(.NUM_CH(4), .PRESCALE(1), .TIMEOUT_TICKS(100)) dutSat (
    .Clk(clk), .ResetN(resetN2), .Addr(addr2), .DataRd(dataRd2), .DataWr(16'h0000),
    .En(1'b0), .Rd(1'b0), .Wr(1'b0),
`ifdef RCCAP_IRQ_EN
    .Irq(irq2),
`endif
    .P(p2));
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic peek(input logic [4:0] a, output logic [15:0] v);
    addr = a;
    #1 v = dataRd;
  endtask
  task automatic rdReg(input logic [4:0] a, output logic [15:0] v);
    addr = a;
    en = 1'b1;
    rd = 1'b1;
    #1 v = dataRd;
    @(negedge clk);
    en = 1'b0;
    rd = 1'b0;
  endtask
  task automatic wrReg(input logic [4:0] a, input logic [15:0] v);
    addr = a;
    dataWr = v;
    en = 1'b1;
    wr = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wr = 1'b0;
  endtask
  task automatic pulse(input int ch, input int clks);
    p[ch] = 1'b1;
    cyc(clks);
    p[ch] = 1'b0;
  endtask
  // Saturation: 66000 ticks at PRESCALE=1 must stop at FFFF rather than wrap.
  initial begin
    cyc(3);
    resetN2 = 1'b1;
    cyc(3);
    p2[3] = 1'b1;
    cyc(66000);
    p2[3] = 1'b0;
    cyc(5);
    addr2 = 5'd3;
    #1 check("sat_width", dataRd2, 16'hFFFF);
    addr2 = 5'h1E;
    #1 check("sat_new", dataRd2, 16'h0008);
    satDone = 1'b1;
  end
  initial begin
    cyc(3);
    peek(5'd0, d);  check("rst_width0", d, 16'h0000);
    peek(5'h1D, d); check("rst_enable", d, 16'h00FF);
    peek(5'h1E, d); check("rst_new", d, 16'h0000);
    peek(5'h1F, d); check("rst_lost", d, 16'h0000);
    resetN = 1'b1;
    cyc(5);
    pulse(0, 6000);
    cyc(5);
    peek(5'h1E, d); check("a_new", d, 16'h0001);
    peek(5'h1F, d); check("a_lost", d, 16'h00FE);
    rdReg(5'd0, d); check("a_width_1500", 16'(d >= 1499 && d <= 1501), 16'd1);
    peek(5'h1E, d); check("a_new_clr", d, 16'h0000);
    pulse(5, 40);
    cyc(5);
    peek(5'h1F, d); check("c_lost_clr", d, 16'h00DE);
    peek(5'h1E, d); check("c_new", d, 16'h0020);
    rdReg(5'd5, d); check("c_width_10", 16'(d >= 9 && d <= 11), 16'd1);
    pulse(2, 20);
    cyc(5);
    rdReg(5'd2, d); check("d_width_5", 16'(d >= 4 && d <= 5), 16'd1);
    pulse(2, 40);
    cyc(2);
    rdReg(5'd2, d); check("d_old_width", 16'(d >= 4 && d <= 5), 16'd1);
    peek(5'h1E, d); check("d_new_kept", d, 16'h0004);
    rdReg(5'd2, d); check("d_new_width", 16'(d >= 9 && d <= 11), 16'd1);
    peek(5'h1E, d); check("d_new_clr", d, 16'h0000);
    pulse(0, 20);
    cyc(5);
    peek(5'h1E, d); check("e_new_pre", d, 16'h0001);
    p[0] = 1'b1;
    cyc(20);
    wrReg(5'h1D, 16'h00FE);
    cyc(2);
    peek(5'h1E, d); check("e_new_dis", d, 16'h0000);
    p[0] = 1'b0;
    cyc(10);
    peek(5'h1E, d); check("e_no_latch", d, 16'h0000);
    peek(5'd0, d);  check("e_width_held", 16'(d >= 4 && d <= 5), 16'd1);
    peek(5'h1D, d); check("e_enable_rd", d, 16'h00FE);
    cyc(500);
    peek(5'h1F, d); check("e_lost0_dis", d & 16'h0001, 16'h0000);
    wrReg(5'h1D, 16'h00FF);
    peek(5'h1D, d); check("e_enable_on", d, 16'h00FF);
`ifdef RCCAP_IRQ_EN
    wrReg(5'h1C, 16'h0001);
    peek(5'h1C, d); check("i_mask", d, 16'h0001);
    check("i_irq_idle", 16'(irq), 16'd0);
    pulse(0, 20);
    cyc(3);
    peek(5'h1E, d); check("i_new0", d & 16'h0001, 16'h0001);
    check("i_irq_lag", 16'(irq), 16'd0);
    cyc(1);
    check("i_irq_rise", 16'(irq), 16'd1);
    rdReg(5'd0, d);
    check("i_irq_hold", 16'(irq), 16'd1);
    cyc(1);
    check("i_irq_fall", 16'(irq), 16'd0);
`else
    wrReg(5'h1C, 16'h0001);
    peek(5'h1C, d); check("i_mask_absent", d, 16'h0000);
`endif
    p[1] = 1'b1;
    cyc(20);
    resetN = 1'b0;
    cyc(3);
    peek(5'h1E, d); check("f_rst_new", d, 16'h0000);
    peek(5'h1D, d); check("f_rst_enable", d, 16'h00FF);
    resetN = 1'b1;
    cyc(20);
    p[1] = 1'b0;
    cyc(10);
    peek(5'h1E, d); check("f_no_capture", d, 16'h0000);
    peek(5'd1, d);  check("f_width_zero", d, 16'h0000);
    pulse(1, 40);
    cyc(5);
    peek(5'h1E, d); check("f_new", d, 16'h0002);
    rdReg(5'd1, d); check("f_width_10", 16'(d >= 9 && d <= 11), 16'd1);
    wrReg(5'h10, 16'hFFFF);
    peek(5'h10, d); check("unused_addr", d, 16'h0000);
    peek(5'h1D, d); check("unused_no_side", d, 16'h00FF);
    for (int i = 0; i < 80000 && !satDone; i++) @(negedge clk);
    check("sat_done", 16'(satDone), 16'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
